// File: rtl/ray_dispatch_scheduler_pkg.sv
// rtl/ray_dispatch_scheduler_pkg.sv - shared frame geometry, pixel types and scheduler states
package ray_dispatch_scheduler_pkg;

  localparam int H_RES_DEF   = 320;
  localparam int V_RES_DEF   = 240;
  localparam int COLOR_W_DEF = 12;
  localparam int ADDR_W_DEF  = 17;

  typedef logic [COLOR_W_DEF-1:0] color_t;
  typedef logic [ADDR_W_DEF-1:0]  fb_addr_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} sched_state_t;

  // Raster-order linear pixel index; callers truncate to their address width.
  function automatic logic [31:0] pixel_index(input logic [8:0] h, input logic [7:0] v,
                                              input int h_res);
    return 32'(v) * 32'(h_res) + 32'(h);
  endfunction

endpackage

// File: rtl/ray_dispatch_scheduler_rr_arbiter.sv
// rtl/ray_dispatch_scheduler_rr_arbiter.sv - round-robin arbiter, search starts after the last grant
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant,
  output logic         grant_valid
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] next_ptr;

  always_comb begin
    int idx;
    grant       = '0;
    grant_valid = 1'b0;
    next_ptr    = ptr;
    idx         = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!grant_valid && req[idx]) begin
        grant[idx]  = 1'b1;
        grant_valid = 1'b1;
        next_ptr    = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && grant_valid) begin
      ptr <= next_ptr;
    end
  end

endmodule

// File: rtl/ray_dispatch_scheduler.sv
// rtl/ray_dispatch_scheduler.sv - raster-order pixel dispatch to ray-marcher cores
// and round-robin writeback of their results to the framebuffer.
module ray_dispatch_scheduler
  import ray_dispatch_scheduler_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int H_RES     = H_RES_DEF,
  parameter int V_RES     = V_RES_DEF,
  parameter int COLOR_W   = COLOR_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           frame_start_in,
  output logic [NUM_CORES-1:0]           core_start_out,
  output logic [8:0]                     core_hcount_out,
  output logic [7:0]                     core_vcount_out,
  input  logic [NUM_CORES-1:0]           core_valid_in,
  input  logic [NUM_CORES*COLOR_W-1:0]   core_color_in,
  output logic [NUM_CORES-1:0]           core_ack_out,
  output logic                           fb_we_out,
  output logic [ADDR_W-1:0]              fb_addr_out,
  output logic [COLOR_W-1:0]             fb_data_out,
  output logic                           busy_out,
  output logic                           frame_done_out
);

  localparam int IW = $clog2(NUM_CORES);

  sched_state_t         state;
  logic [8:0]           h;
  logic [7:0]           v;
  logic [NUM_CORES-1:0] idle;
  logic [ADDR_W-1:0]    addr_reg [NUM_CORES];

  logic [IW-1:0]        disp_idx;
  logic                 disp_valid;
  logic                 last_pixel;
  logic [ADDR_W-1:0]    pix_addr;

  logic                 wb_active;
  logic [NUM_CORES-1:0] wb_req;
  logic [NUM_CORES-1:0] wb_grant;
  logic                 wb_grant_valid;
  logic [ADDR_W-1:0]    sel_addr;
  logic [COLOR_W-1:0]   sel_color;

  // Fixed-priority pick of the lowest idle core; bus outputs come straight from state.
  always_comb begin
    disp_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (idle[i]) disp_idx = IW'(i);
    end
    disp_valid     = (state == S_RUN) && (|idle);
    core_start_out = '0;
    if (disp_valid) core_start_out[disp_idx] = 1'b1;
    core_hcount_out = disp_valid ? h : '0;
    core_vcount_out = disp_valid ? v : '0;
    pix_addr        = ADDR_W'(pixel_index(h, v, H_RES));
    last_pixel      = (h == 9'(H_RES - 1)) && (v == 8'(V_RES - 1));
    busy_out        = (state == S_RUN) || (state == S_DRAIN);
    frame_done_out  = (state == S_DONE);
  end

  // A core being acked this cycle still looks busy; mask it so it is not granted twice.
  always_comb begin
    wb_active = (state == S_RUN) || (state == S_DRAIN);
    wb_req    = wb_active ? (core_valid_in & ~idle & ~core_ack_out) : '0;
    sel_addr  = '0;
    sel_color = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (wb_grant[i]) begin
        sel_addr  = addr_reg[i];
        sel_color = core_color_in[i*COLOR_W +: COLOR_W];
      end
    end
  end

  rr_arbiter #(.N(NUM_CORES)) u_rr_arbiter (
    .clk         (clk_in),
    .rst         (rst_in),
    .req         (wb_req),
    .advance     (wb_grant_valid),
    .grant       (wb_grant),
    .grant_valid (wb_grant_valid)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state        <= S_IDLE;
      h            <= '0;
      v            <= '0;
      idle         <= '1;
      for (int i = 0; i < NUM_CORES; i++) addr_reg[i] <= '0;
      core_ack_out <= '0;
      fb_we_out    <= 1'b0;
      fb_addr_out  <= '0;
      fb_data_out  <= '0;
    end else begin
      core_ack_out <= wb_grant;
      fb_we_out    <= wb_grant_valid;
      fb_addr_out  <= wb_grant_valid ? sel_addr : '0;
      fb_data_out  <= wb_grant_valid ? sel_color : '0;
      idle         <= (idle & ~core_start_out) | core_ack_out;
      if (disp_valid) addr_reg[disp_idx] <= pix_addr;

      case (state)
        S_IDLE: begin
          if (frame_start_in) begin
            state <= S_RUN;
            h     <= '0;
            v     <= '0;
          end
        end
        S_RUN: begin
          if (disp_valid) begin
            if (last_pixel) begin
              state <= S_DRAIN;
              h     <= '0;
              v     <= '0;
            end else if (h == 9'(H_RES - 1)) begin
              h <= '0;
              v <= v + 8'd1;
            end else begin
              h <= h + 9'd1;
            end
          end
        end
        S_DRAIN: begin
          if ((&idle) && (core_ack_out == '0)) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_dispatch_scheduler.sv
// tb/tb_ray_dispatch_scheduler.sv - directed bench: 4 cores on an 8x2 frame
module tb_ray_dispatch_scheduler;

  localparam int NC = 4;
  localparam int HR = 8;
  localparam int VR = 2;
  localparam int CW = 12;
  localparam int AW = 17;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              frame_start_in;
  logic [NC-1:0]     core_start_out;
  logic [8:0]        core_hcount_out;
  logic [7:0]        core_vcount_out;
  logic [NC-1:0]     core_valid_in;
  logic [NC*CW-1:0]  core_color_in;
  logic [NC-1:0]     core_ack_out;
  logic              fb_we_out;
  logic [AW-1:0]     fb_addr_out;
  logic [CW-1:0]     fb_data_out;
  logic              busy_out;
  logic              frame_done_out;

  int n_cmp = 0;
  int n_err = 0;

  ray_dispatch_scheduler #(
    .NUM_CORES(NC), .H_RES(HR), .V_RES(VR), .COLOR_W(CW), .ADDR_W(AW)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .frame_start_in  (frame_start_in),
    .core_start_out  (core_start_out),
    .core_hcount_out (core_hcount_out),
    .core_vcount_out (core_vcount_out),
    .core_valid_in   (core_valid_in),
    .core_color_in   (core_color_in),
    .core_ack_out    (core_ack_out),
    .fb_we_out       (fb_we_out),
    .fb_addr_out     (fb_addr_out),
    .fb_data_out     (fb_data_out),
    .busy_out        (busy_out),
    .frame_done_out  (frame_done_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic cyc();
    @(negedge clk_in);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_write(input string tag, input logic [AW-1:0] a, input logic [CW-1:0] d,
                           input logic [NC-1:0] ack);
    chk({tag, "_we"}, 32'(fb_we_out), 32'd1);
    chk({tag, "_addr"}, 32'(fb_addr_out), 32'(a));
    chk({tag, "_data"}, 32'(fb_data_out), 32'(d));
    chk({tag, "_ack"}, 32'(core_ack_out), 32'(ack));
  endtask

  task automatic chk_disp(input string tag, input logic [NC-1:0] s, input int hh, input int vv);
    chk({tag, "_start"}, 32'(core_start_out), 32'(s));
    chk({tag, "_h"}, 32'(core_hcount_out), 32'(hh));
    chk({tag, "_v"}, 32'(core_vcount_out), 32'(vv));
  endtask

  logic [NC-1:0] pend;
  logic [11:0]   pix [NC];
  logic [15:0]   written;
  int            n_wr;
  int            n_done;

  initial begin
    rst_in = 1'b1; frame_start_in = 1'b0; core_valid_in = '0; core_color_in = '0;

    // Reset state
    cyc();
    chk("rst_start", 32'(core_start_out), 32'd0);
    chk("rst_we", 32'(fb_we_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_done", 32'(frame_done_out), 32'd0);
    chk("rst_ack", 32'(core_ack_out), 32'd0);
    rst_in = 1'b0;
    cyc();
    chk("idle_busy", 32'(busy_out), 32'd0);
    frame_start_in = 1'b1;

    // Dispatch order with cores holding their pixels
    cyc(); frame_start_in = 1'b0;
    chk("run_busy", 32'(busy_out), 32'd1);
    chk_disp("d0", 4'b0001, 0, 0);
    cyc(); chk_disp("d1", 4'b0010, 1, 0);
    cyc(); chk_disp("d2", 4'b0100, 2, 0);
    cyc(); chk_disp("d3", 4'b1000, 3, 0);
    cyc(); chk_disp("d_none", 4'b0000, 0, 0);

    // Round-robin fairness: all four results at once
    core_valid_in = 4'b1111;
    core_color_in = {12'd4, 12'd3, 12'd2, 12'd1};
    cyc(); chk_write("rr0", 0, 12'd1, 4'b0001); chk("rr0_nodisp", 32'(core_start_out), 32'd0);
    core_valid_in = 4'b1110;
    cyc(); chk_write("rr1", 1, 12'd2, 4'b0010); chk_disp("d4", 4'b0001, 4, 0);
    core_valid_in = 4'b1100;
    cyc(); chk_write("rr2", 2, 12'd3, 4'b0100); chk_disp("d5", 4'b0010, 5, 0);
    core_valid_in = 4'b1000;
    cyc(); chk_write("rr3", 3, 12'd4, 4'b1000); chk_disp("d6", 4'b0100, 6, 0);
    core_valid_in = 4'b0000;
    cyc(); chk("rr_end_we", 32'(fb_we_out), 32'd0); chk_disp("d7", 4'b1000, 7, 0);

    // Out-of-order completion across the line wrap
    cyc(); chk("ooo_nodisp", 32'(core_start_out), 32'd0);
    core_valid_in = 4'b1000;
    core_color_in = {12'hABC, 36'h0};
    cyc(); chk_write("ooo7", 7, 12'hABC, 4'b1000);
    chk("ooo_no_early", 32'(core_start_out), 32'd0);
    core_valid_in = 4'b0100;
    core_color_in = {12'h0, 12'h123, 24'h0};
    cyc(); chk_write("ooo6", 6, 12'h123, 4'b0100);
    chk_disp("wrap", 4'b1000, 0, 1);

    // Remaining pixels with responsive cores; color equals the pixel index
    pend = 4'b1011;
    pix[0] = 12'd4; pix[1] = 12'd5; pix[2] = 12'd0; pix[3] = 12'd8;
    written = 16'h00CF;
    n_wr = 0; n_done = 0;
    core_valid_in = pend;
    for (int i = 0; i < NC; i++) core_color_in[i*CW +: CW] = pix[i];
    for (int it = 0; it < 60; it++) begin
      cyc();
      if (fb_we_out) begin
        n_wr++;
        chk("wb_data_vs_addr", 32'(fb_data_out), 32'(fb_addr_out));
        chk("wb_range", 32'(fb_addr_out < AW'(16)), 32'd1);
        chk("wb_unique", 32'(written[fb_addr_out[3:0]]), 32'd0);
        chk("wb_ack_busy_core", 32'((core_ack_out & ~pend) == '0 && core_ack_out != '0), 32'd1);
        written[fb_addr_out[3:0]] = 1'b1;
      end
      for (int i = 0; i < NC; i++) begin
        if (core_ack_out[i]) pend[i] = 1'b0;
        if (core_start_out[i]) begin
          pend[i] = 1'b1;
          pix[i]  = 12'(core_vcount_out) * 12'(HR) + 12'(core_hcount_out);
        end
      end
      if (frame_done_out) begin
        n_done++;
        chk("done_busy", 32'(busy_out), 32'd0);
      end
      core_valid_in = pend;
      for (int i = 0; i < NC; i++) core_color_in[i*CW +: CW] = pix[i];
      frame_start_in = (it == 2);
    end
    chk("frame_done_count", 32'(n_done), 32'd1);
    chk("tail_writes", 32'(n_wr), 32'd10);
    chk("all_written", 32'(written), 32'hFFFF);
    chk("post_busy", 32'(busy_out), 32'd0);

    // Valid from idle cores is ignored
    core_valid_in = 4'b1111;
    core_color_in = {12'h111, 12'h222, 12'h333, 12'h444};
    cyc(); cyc();
    chk("idlev_we", 32'(fb_we_out), 32'd0);
    chk("idlev_ack", 32'(core_ack_out), 32'd0);
    cyc();
    chk("idlev_we2", 32'(fb_we_out), 32'd0);
    core_valid_in = '0;

    // Asynchronous reset mid-frame with a write in flight
    frame_start_in = 1'b1;
    cyc(); frame_start_in = 1'b0;
    chk_disp("r_d0", 4'b0001, 0, 0);
    core_valid_in = 4'b0001;
    core_color_in = {36'h0, 12'h555};
    cyc(); chk_disp("r_d1", 4'b0010, 1, 0);
    cyc(); chk_write("r_w0", 0, 12'h555, 4'b0001); chk_disp("r_d2", 4'b0100, 2, 0);
    #2 rst_in = 1'b1;
    #1;
    chk("arst_start", 32'(core_start_out), 32'd0);
    chk("arst_h", 32'(core_hcount_out), 32'd0);
    chk("arst_we", 32'(fb_we_out), 32'd0);
    chk("arst_addr", 32'(fb_addr_out), 32'd0);
    chk("arst_data", 32'(fb_data_out), 32'd0);
    chk("arst_ack", 32'(core_ack_out), 32'd0);
    chk("arst_busy", 32'(busy_out), 32'd0);
    chk("arst_done", 32'(frame_done_out), 32'd0);
    cyc(); rst_in = 1'b0; core_valid_in = '0;
    cyc();
    chk("post_rst_busy", 32'(busy_out), 32'd0);
    chk("post_rst_start", 32'(core_start_out), 32'd0);
    frame_start_in = 1'b1;
    cyc(); frame_start_in = 1'b0;
    chk("restart_busy", 32'(busy_out), 32'd1);
    chk_disp("restart", 4'b0001, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ray_dispatch_scheduler.md
Name: ray_dispatch_scheduler

Overview:
- Sequences one frame of ray marching: walks pixel coordinates in raster order and hands each pixel to one of NUM_CORES ray-marcher cores.
- Arbitrates the cores' finished results round-robin onto the single framebuffer BRAM write port.
- Sits in top_level_main between the frame-trigger logic (buttons/vsync) and the core array and framebuffer.

Parameters:
- NUM_CORES, 4, number of ray-marcher cores served (2..8).
- H_RES, 320, pixels per line.
- V_RES, 240, lines per frame.
- COLOR_W, 12, pixel color width (4:4:4 RGB).
- ADDR_W, 17, framebuffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES.

Ports:
- clk_in  input  1  system clock; single clock domain.
- rst_in  input  1  asynchronous, active-high reset.
- frame_start_in  input  1  pulse; starts a frame when idle.
- core_start_out  output  NUM_CORES  one-hot, single-cycle dispatch strobe.
- core_hcount_out  output  9  dispatched pixel x; shared bus, valid with the strobe.
- core_vcount_out  output  8  dispatched pixel y; shared bus, valid with the strobe.
- core_valid_in  input  NUM_CORES  core holds a finished result; level, held until acked.
- core_color_in  input  NUM_CORES*COLOR_W  per-core result color; core i in slice [i*COLOR_W +: COLOR_W].
- core_ack_out  output  NUM_CORES  one-hot, single-cycle result acknowledge.
- fb_we_out  output  1  framebuffer write enable.
- fb_addr_out  output  ADDR_W  framebuffer write address.
- fb_data_out  output  COLOR_W  framebuffer write data.
- busy_out  output  1  high from frame start until frame done.
- frame_done_out  output  1  single-cycle pulse when the last pixel has been written.

Behaviour:
- Reset (async, any time, including mid-frame):
  - all outputs 0; state IDLE; pixel counters 0; all cores marked idle; round-robin pointer 0; per-core address registers 0.
  - In-flight core results are abandoned; the core array is reset by the same rst_in.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: on frame_start_in go to RUN next cycle with h=0, v=0. busy_out=1 from that cycle.
  - RUN: dispatch and writeback both active. After dispatching pixel (H_RES-1, V_RES-1), go to DRAIN.
  - DRAIN: writeback only. When every core is idle and no ack is pending, go to DONE.
  - DONE: frame_done_out=1 for one cycle; busy_out=0; return to IDLE.
- frame_start_in outside IDLE is ignored; it is not queued.
- Dispatch (RUN only):
  - At most one core per cycle, chosen as the lowest-index core whose internal idle flag is set.
  - That cycle: core_start_out[i]=1, the hcount/vcount buses carry the pixel, idle[i] is cleared, and addr_reg[i] = v*H_RES + h.
  - Counters advance: h wraps at H_RES-1 to 0 and increments v.
  - No idle core means no strobe, and the counters hold.
- Writeback (RUN and DRAIN):
  - Round-robin across cores with core_valid_in[i]=1 and idle[i]=0. Search starts at the index after the last granted core.
  - Grant to core i registers, one cycle latency:
    - fb_we_out=1, fb_addr_out=addr_reg[i], fb_data_out=core_color_in[i] (sampled in the grant cycle);
    - core_ack_out[i]=1 in that same output cycle; idle[i] is set at the end of it.
  - One write per cycle maximum.
- Simultaneity and ordering:
  - A core acked in cycle t is eligible for dispatch from cycle t+1 at the earliest.
  - Dispatch and writeback of different cores in the same cycle are both allowed.
  - core_valid_in asserted on a core that is idle is ignored (protocol error, no write).
- Arithmetic:
  - The address product uses a constant multiply and is truncated to ADDR_W.
  - hcount/vcount are unsigned; buses read 0 when no strobe.
- Throughput bound: one pixel dispatched per cycle; a frame takes at least H_RES*V_RES+2 cycles.

Decomposition:
- Shared package (types.svh): color_t (COLOR_W), fb_addr_t (ADDR_W), and the H_RES/V_RES constants, so they are shared with the VGA/BRAM logic.
- One sub-module: rr_arbiter (parameter N).
  - Inputs: req[N], advance.
  - Outputs: one-hot grant, grant_valid.
  - Keeps the pointer internally and is reused elsewhere.
- Dispatch selection is a fixed-priority encoder kept inline.

Test Plan:
- Reset mid-frame: assert rst_in asynchronously during RUN at pixel (100,50) -> all outputs 0 immediately, without waiting for a clock; after release busy_out=0; the next frame_start_in restarts at (0,0).
- Tiny frame, single immediate core: H_RES=4, V_RES=2, NUM_CORES=1, core returns valid with color=12'hF00 one cycle after start -> 8 writes to addresses 0..7, all 12'hF00; frame_done_out pulses exactly once; busy_out low afterwards.
- Dispatch order: NUM_CORES=4, all idle, cores never return -> starts on cores 0,1,2,3 in consecutive cycles with (h,v)=(0,0),(1,0),(2,0),(3,0); then no strobes.
- Round-robin fairness: cores 0–3 each holding a result (colors 1,2,3,4 at addresses 0..3), asserted together -> writes come out in order core0, core1, core2, core3 on consecutive cycles, each with the matching ack, and data/address pairs (0,1),(1,2),(2,3),(3,4).
- Out-of-order completion plus line wrap: H_RES=320, 2 cores. Core1, holding pixel (319,0), finishes before core0, holding (318,0) -> write addr 319 precedes addr 318. Next dispatch to core1 is (0,1) with addr_reg=320, and it issues no earlier than the cycle after the ack.
- Ignored start and idle-valid: frame_start_in pulsed during RUN -> no effect, exactly one frame_done_out. core_valid_in raised on an idle core -> no fb_we_out, no ack.
